addround_engine: RTL and testbench

ADDROUND_ENGINE -- requirements
Module: addround_engine

---
 rtl/addround_engine.sv | 98 +++++++++
 tb/tb_addround_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addround_engine.sv
// AddRoundKey engine: XORs a captured 128-bit round key into a captured state, LANES bytes per cycle,
// then holds the result until the consumer takes it. One block in flight at a time.
module addround_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         around_enable,
  input  logic [127:0] subkey,
  input  logic [127:0] olddata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] newdata,
  output logic [7:0]   block_count
);

  localparam int BEATS = 16 / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_XOR, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   key_q;
  logic           mode_q;
  logic [7:0]     count_q;

  assign beat_d = beat_q + 1'b1;

  // Each byte belongs to exactly one beat; it is rewritten only while that beat is active.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam logic [BW-1:0] BYTE_BEAT = BW'(gi / LANES);
    assign data_d[8*gi +: 8] = (state_q == S_XOR && beat_q == BYTE_BEAT && mode_q)
                               ? (data_q[8*gi +: 8] ^ key_q[8*gi +: 8])
                               : data_q[8*gi +: 8];
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_XOR;
      S_XOR:   if (beat_q == LAST_BEAT) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is masked by reset so nothing is offered while the block is held in reset.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !n_rst;
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      data_q  <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      beat_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_q <= olddata;
            key_q  <= subkey;
            mode_q <= around_enable;
            beat_q <= '0;
          end
        end
        S_XOR: begin
          data_q <= data_d;
          beat_q <= beat_d;
        end
        S_DONE: begin
          if (out_ready) count_q <= count_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign newdata     = data_q;
  assign block_count = count_q;

endmodule

// File: tb/tb_addround_engine.sv
// Bench for addround_engine: directed vectors, lane-count variants, stall, mid-block reset,
// randomized blocks and a 256-block back-to-back run, all against a plain XOR reference.
module tb_addround_engine;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         around_enable = 1'b0;
  logic [127:0] subkey = '0;
  logic [127:0] olddata = '0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_valid;
  logic [127:0] newdata;
  logic [7:0]   block_count;
  logic         in_ready_l1, out_valid_l1, in_ready_l16, out_valid_l16;
  logic [127:0] newdata_l1, newdata_l16;
  logic [7:0]   block_count_l1, block_count_l16;

  int checks = 0;
  int errors = 0;
  logic [7:0] bc_model = 8'd0;

  localparam logic [127:0] VEC_OLD = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_XOR = 128'h00102030405060708090a0b0c0d0e0f0;

  always #5 clk = ~clk;

  addround_engine #(.LANES(4)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .around_enable(around_enable), .subkey(subkey), .olddata(olddata),
    .out_valid(out_valid), .out_ready(out_ready), .newdata(newdata), .block_count(block_count)
  );

  addround_engine #(.LANES(1)) dut_l1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_l1),
    .around_enable(around_enable), .subkey(subkey), .olddata(olddata),
    .out_valid(out_valid_l1), .out_ready(out_ready), .newdata(newdata_l1), .block_count(block_count_l1)
  );

  addround_engine #(.LANES(16)) dut_l16 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_l16),
    .around_enable(around_enable), .subkey(subkey), .olddata(olddata),
    .out_valid(out_valid_l16), .out_ready(out_ready), .newdata(newdata_l16), .block_count(block_count_l16)
  );

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] ref_result(input logic [127:0] od, input logic [127:0] sk, input logic md);
    return md ? (od ^ sk) : od;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    n_rst = 1'b0;
    bc_model = 8'd0;
    tick();
  endtask

  // Runs one block through the LANES=4 instance; expects it idle on entry.
  task automatic do_block(input logic [127:0] od, input logic [127:0] sk, input logic md,
                          input int stall, input string tag);
    logic [127:0] exp;
    int lat;
    exp = ref_result(od, sk, md);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %b expected 1", tag, in_ready);
    end
    olddata = od; subkey = sk; around_enable = md; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      olddata = rand128(); subkey = rand128(); around_enable = $urandom_range(0, 1);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy_ready: got %b expected 0", tag, in_ready);
      end
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL %s latency: got %0d expected 4", tag, lat);
    end
    checks++;
    if (newdata !== exp) begin
      errors++; $display("FAIL %s newdata: got %h expected %h", tag, newdata, exp);
    end
    for (int i = 0; i < stall; i++) begin
      olddata = rand128(); subkey = rand128(); around_enable = $urandom_range(0, 1);
      tick();
      checks++;
      if (newdata !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s stall: got data=%h ov=%b ir=%b expected data=%h ov=1 ir=0",
                 tag, newdata, out_valid, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    bc_model = bc_model + 8'd1;
    checks++;
    if (block_count !== bc_model || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: got bc=%0d ov=%b ir=%b expected bc=%0d ov=0 ir=1",
               tag, block_count, out_valid, in_ready, bc_model);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || newdata !== 128'd0 || block_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got ir=%b ov=%b data=%h bc=%0d expected all zero",
               in_ready, out_valid, newdata, block_count);
    end
    n_rst = 1'b0;
    bc_model = 8'd0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    olddata = VEC_OLD; subkey = VEC_KEY; around_enable = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    bc_model = 8'd0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || newdata !== 128'd0 || in_ready !== 1'b0 || block_count !== 8'd0) begin
      errors++;
      $display("FAIL midreset_async: got ov=%b data=%h ir=%b bc=%0d expected 0,0,0,0",
               out_valid, newdata, in_ready, block_count);
    end
    #2;
    n_rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b0 || block_count !== 8'd0 || newdata !== 128'd0) begin
        errors++;
        $display("FAIL midreset_quiet: got ov=%b bc=%0d data=%h expected 0,0,0", out_valid, block_count, newdata);
      end
      tick();
    end
    do_block(VEC_OLD, VEC_KEY, 1'b1, 0, "midreset_next");
  endtask

  task automatic test_vectors();
    do_block(VEC_OLD, VEC_KEY, 1'b1, 0, "vec_xor");
    do_block(VEC_OLD, VEC_KEY, 1'b0, 0, "vec_pass");
    checks++;
    if (ref_result(VEC_OLD, VEC_KEY, 1'b1) !== VEC_XOR) begin
      errors++; $display("FAIL vec_model: got %h expected %h", ref_result(VEC_OLD, VEC_KEY, 1'b1), VEC_XOR);
    end
  endtask

  task automatic test_lanes();
    int lat1, lat4, lat16;
    do_reset();
    checks++;
    if (in_ready_l1 !== 1'b1 || in_ready_l16 !== 1'b1) begin
      errors++; $display("FAIL lanes_ready: got l1=%b l16=%b expected 1,1", in_ready_l1, in_ready_l16);
    end
    olddata = VEC_OLD; subkey = VEC_KEY; around_enable = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat1 = -1; lat4 = -1; lat16 = -1;
    for (int k = 1; k <= 20; k++) begin
      olddata = rand128(); subkey = rand128();
      tick();
      if (out_valid_l1 === 1'b1 && lat1 < 0) lat1 = k;
      if (out_valid === 1'b1 && lat4 < 0) lat4 = k;
      if (out_valid_l16 === 1'b1 && lat16 < 0) lat16 = k;
    end
    checks++;
    if (lat1 !== 16 || lat4 !== 4 || lat16 !== 1) begin
      errors++; $display("FAIL lanes_latency: got l1=%0d l4=%0d l16=%0d expected 16,4,1", lat1, lat4, lat16);
    end
    checks++;
    if (newdata_l1 !== VEC_XOR || newdata !== VEC_XOR || newdata_l16 !== VEC_XOR) begin
      errors++;
      $display("FAIL lanes_data: got l1=%h l4=%h l16=%h expected %h", newdata_l1, newdata, newdata_l16, VEC_XOR);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    bc_model = bc_model + 8'd1;
    checks++;
    if (block_count_l1 !== 8'd1 || block_count !== bc_model || block_count_l16 !== 8'd1) begin
      errors++;
      $display("FAIL lanes_count: got l1=%0d l4=%0d l16=%0d expected 1", block_count_l1, block_count, block_count_l16);
    end
  endtask

  task automatic test_stall();
    do_block(rand128(), rand128(), 1'b1, 10, "stall");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      do_block(rand128(), rand128(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q_exp[$];
    logic [127:0] od, sk;
    logic md;
    logic prev_hs;
    int hs, ir_cnt, cyc;
    do_reset();
    hs = 0; ir_cnt = 0; cyc = 0; prev_hs = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (hs < 256 && cyc < 4000) begin
      if (prev_hs) bc_model = bc_model + 8'd1;
      checks++;
      if (block_count !== bc_model) begin
        errors++; $display("FAIL b2b_count: got %0d expected %0d", block_count, bc_model);
      end
      prev_hs = 1'b0;
      if (out_valid === 1'b1) begin
        checks++;
        if (q_exp.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: got output %h expected none", newdata);
        end else begin
          od = q_exp.pop_front();
          if (newdata !== od) begin
            errors++; $display("FAIL b2b_data: got %h expected %h", newdata, od);
          end
        end
        if (hs > 0) begin
          checks++;
          if (ir_cnt !== 1) begin
            errors++; $display("FAIL b2b_ready_gap: got %0d cycles expected 1", ir_cnt);
          end
        end
        ir_cnt = 0;
        hs++;
        prev_hs = 1'b1;
      end
      od = rand128(); sk = rand128(); md = 1'($urandom_range(0, 1));
      olddata = od; subkey = sk; around_enable = md;
      if (in_ready === 1'b1) begin
        ir_cnt++;
        q_exp.push_back(ref_result(od, sk, md));
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (prev_hs) bc_model = bc_model + 8'd1;
    checks++;
    if (hs !== 256) begin
      errors++; $display("FAIL b2b_timeout: got %0d handshakes expected 256", hs);
    end
    checks++;
    if (block_count !== 8'd0) begin
      errors++; $display("FAIL b2b_wrap: got %0d expected 0", block_count);
    end
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_vectors();
    test_lanes();
    test_stall();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
